mux_rr_arb: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered multiplexer with built-in arbitration and a valid/ready handshake on every side.
- Successor to the fixed 2:1, 1-bit select-driven mux cell. Channel selection is made internally, either fixed-priority or round-robin, instead of by an external select pin.
- Sits between several producer streams and one shared consumer (shared bus or port), giving one cycle of registered latency.

---
 rtl/mux_rr_arb_if.sv | 27 ++
 rtl/mux_rr_arb.sv | 77 +++++++
 tb/tb_mux_rr_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mux_rr_arb_if.sv
// Stream bundle between N_CH producers, the arbitrating mux and one consumer.
// The mux takes the slave view; the environment driving it takes the master view.
interface mux_rr_arb_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    mode;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic [N_CH-1:0]         in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_rr_arb.sv
// N-channel registered mux with internal fixed-priority / round-robin arbitration.
// One output register; refills in the same cycle it drains.
module mux_rr_arb #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux_rr_arb_if.slave     bus
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_load_en;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt;
    logic [WIDTH-1:0] w_gnt_data;
    logic [N_CH-1:0]  w_in_ready;
    logic             w_xfer;

    assign w_load_en = !r_out_valid || bus.out_ready;

    // Search starts at 0 in fixed mode, at the pointer in round-robin mode.
    always_comb begin : p_grant
        logic [SEL_W-1:0] w_idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            w_idx = bus.mode ? SEL_W'((32'(r_ptr) + k) % N_CH) : SEL_W'(k);
            if (!w_gnt_vld && bus.in_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    always_comb begin : p_data_mux
        w_gnt_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_in_ready = (!rst && w_load_en && w_gnt_vld) ? (N_CH'(1) << w_gnt) : '0;
    assign w_xfer     = |(w_in_ready & bus.in_valid);

    // Reset drops any held word without completing its handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt;
            if (bus.mode) begin
                r_ptr <= (w_gnt == SEL_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: directed scenarios followed by random traffic,
// checked against a queue-based model of the arbitration rules.
module tb_mux_rr_arb;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               sel;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_rr_arb_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    mux_rr_arb #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    word_t           q[$];
    bit              m_full   = 1'b0;
    int              m_ptr    = 0;
    logic [N_CH-1:0] exp_ready = '0;
    bit              exp_valid = 1'b0;
    bit              checking  = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Apply one cycle of inputs and advance the model by the edge that follows.
    task automatic step(input bit r, input bit md, input logic [N_CH-1:0] v,
                        input logic [N_CH*WIDTH-1:0] d, input bit ordy);
        int    g;
        bit    ld;
        word_t w;
        @(posedge clk);
        #1;
        rst           = r;
        bus.mode      = md;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        exp_valid = m_full;
        g = -1;
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = md ? (m_ptr + k) % N_CH : k;
            if (g < 0 && v[c]) g = c;
        end
        ld = !m_full || ordy;
        exp_ready = (!r && ld && g >= 0) ? N_CH'(1 << g) : '0;
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (exp_ready != '0) begin
            w.data = d[g*WIDTH +: WIDTH];
            w.sel  = g;
            q.push_back(w);
            m_full = 1'b1;
            if (md) m_ptr = (g + 1) % N_CH;
        end else if (ordy) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: handshake signals every cycle, held word against the queue head.
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("out_word_expected", 32'(1), 32'(0));
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(q[0].data));
                    chk("out_sel", 32'(bus.out_sel), 32'(q[0].sel));
                    if (!rst && bus.out_ready) void'(q.pop_front());
                end
            end
            if (rst) q.delete();
        end
    end

    initial begin
        bus.mode      = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held for two cycles with every channel requesting.
        step(1'b1, 1'b0, 4'b1111, 32'hDDCCBBAA, 1'b0);
        checking = 1'b1;
        step(1'b1, 1'b0, 4'b1111, 32'hDDCCBBAA, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("reset_out_data", 32'(bus.out_data), 32'h0);
        chk("reset_out_sel", 32'(bus.out_sel), 32'h0);
        step(1'b0, 1'b0, 4'b1111, 32'hDDCCBBAA, 1'b1);

        // Fixed priority: ch1 always beats ch3.
        repeat (3) step(1'b0, 1'b0, 4'b1010, 32'h33001100, 1'b1);

        // Round-robin across all four channels, wrapping.
        repeat (6) step(1'b0, 1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1);

        // Backpressure on a ch2 word, then drain and next grant from ptr=3.
        step(1'b0, 1'b1, 4'b0100, 32'h005C0000, 1'b1);
        repeat (3) step(1'b0, 1'b1, 4'b1111, 32'h44332211, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 1'b1, 4'b1111, 32'h44332211, 1'b1);

        // Drain and refill in the same cycle.
        step(1'b0, 1'b1, 4'b0010, 32'h00007700, 1'b1);
        step(1'b0, 1'b1, 4'b0000, 32'h0, 1'b1);

        // Reset with ptr=2, then mode switch keeps the pointer.
        step(1'b1, 1'b1, 4'b0000, 32'h0, 1'b0);
        step(1'b0, 1'b1, 4'b0101, 32'h00C000B0, 1'b1);
        step(1'b0, 1'b0, 4'b0110, 32'h00E0D000, 1'b1);
        step(1'b0, 1'b1, 4'b0110, 32'h00E1D100, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(39) == 0), 1'($urandom_range(1)),
                 N_CH'($urandom), 32'($urandom), ($urandom_range(9) < 7));
        end

        repeat (3) step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
